// File: rtl/ysyx_22051086_id_ibuf_if.sv
// IF -> IB -> ID handshake bundle: valid/allowin on both sides plus the {pc, inst} buses.
// slave modport is the buffer's view; master modport is the surrounding pipeline's view.
// Signals: if_to_ib_valid/ib_allowin/if_to_ib_bus (fetch side), ib_to_id_valid/id_allowin/ib_to_id_bus (decode side).
interface ysyx_22051086_id_ibuf_if #(
    parameter int DATA_W = 96
);
    logic              if_to_ib_valid;
    logic              ib_allowin;
    logic [DATA_W-1:0] if_to_ib_bus;
    logic              ib_to_id_valid;
    logic              id_allowin;
    logic [DATA_W-1:0] ib_to_id_bus;

    modport slave (
        input  if_to_ib_valid,
        input  if_to_ib_bus,
        input  id_allowin,
        output ib_allowin,
        output ib_to_id_valid,
        output ib_to_id_bus
    );

    modport master (
        output if_to_ib_valid,
        output if_to_ib_bus,
        output id_allowin,
        input  ib_allowin,
        input  ib_to_id_valid,
        input  ib_to_id_bus
    );
endinterface

// File: rtl/ysyx_22051086_id_ibuf.sv
// Instruction buffer between IFU and IDU: DEPTH-entry circular FIFO of {pc, inst} bundles with redirect flush.
// Latency: 1 cycle push-to-head; 0 cycles on an empty buffer when YSYX_22051086_IBUF_BYPASS_EN is defined.
// Backpressure: ib_allowin = !full || pop || flush, combinational on id_allowin; flush drops everything incl. same-cycle push.
// Ports: clk, rst (async active-high), ib (slave modport of ysyx_22051086_id_ibuf_if),
//        flush, ib_count (occupancy 0..DEPTH), ib_full, ib_empty.
module ysyx_22051086_id_ibuf #(
    parameter int DATA_W = 96,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    ysyx_22051086_id_ibuf_if.slave      ib,
    input  logic                        flush,
    output logic [CNT_W-1:0]            ib_count,
    output logic                        ib_full,
    output logic                        ib_empty
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  rptr;
    logic [CNT_W-1:0]  wptr;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  ridx;
    logic [IDX_W-1:0]  widx;
    logic              push;
    logic              pop;
    logic              byp;
    logic              byp_take;
    logic              wr_en;
    logic              rd_en;

    assign ridx = rptr[IDX_W-1:0];
    assign widx = wptr[IDX_W-1:0];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign ib_empty = (rptr == wptr);
    assign ib_full  = (ridx == widx) && (rptr[CNT_W-1] != wptr[CNT_W-1]);
    assign ib_count = cnt;

`ifdef YSYX_22051086_IBUF_BYPASS_EN
    // An empty buffer forwards the incoming bundle straight to ID in the same cycle.
    assign byp = ib_empty && ib.if_to_ib_valid && !flush;
`else
    assign byp = 1'b0;
`endif

    assign ib.ib_to_id_valid = !ib_empty || byp;
    always_comb begin
        ib.ib_to_id_bus = '0;
        if (!ib_empty) begin
            ib.ib_to_id_bus = mem[ridx];
        end else if (byp) begin
            ib.ib_to_id_bus = ib.if_to_ib_bus;
        end
    end

    assign pop  = ib.ib_to_id_valid && ib.id_allowin;
    // Flush keeps allowin high: the redirect-cycle fetch is accepted and silently dropped.
    assign ib.ib_allowin = !ib_full || pop || flush;
    assign push = ib.if_to_ib_valid && ib.ib_allowin;

    // A bypassed bundle consumed by ID never touches storage or pointers.
    assign byp_take = byp && ib.id_allowin;
    assign wr_en    = push && !flush && !byp_take;
    assign rd_en    = pop  && !flush && !byp_take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            rptr <= wptr;
            cnt  <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + CNT_W'(1);
            end
            if (rd_en) begin
                rptr <= rptr + CNT_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is not reset; valid data is tracked solely by the pointers.
    // When full with push+pop, widx equals ridx: the write lands in the slot being read out.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[widx] <= ib.if_to_ib_bus;
        end
    end
endmodule

// File: tb/tb_ysyx_22051086_id_ibuf.sv
module tb_ysyx_22051086_id_ibuf;
    localparam int DATA_W = 96;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;

    logic             clk;
    logic             rst;
    logic             flush;
    logic [CNT_W-1:0] ib_count;
    logic             ib_full;
    logic             ib_empty;

    ysyx_22051086_id_ibuf_if #(.DATA_W(DATA_W)) ib ();

    ysyx_22051086_id_ibuf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .ib       (ib.slave),
        .flush    (flush),
        .ib_count (ib_count),
        .ib_full  (ib_full),
        .ib_empty (ib_empty)
    );

    int errors = 0;
    int checks = 0;
    logic [DATA_W-1:0] sb [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] bundle(input logic [63:0] pc);
        return {pc, pc[31:0] ^ 32'hA5A5_0013};
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle of stimulus. Acceptance is judged at the negedge, where the
    // expected bundle enters the scoreboard (or the scoreboard is cleared on flush).
    task automatic cycle(input logic v, input logic [63:0] pc, input logic a, input logic f);
        ib.if_to_ib_valid = v;
        ib.if_to_ib_bus   = bundle(pc);
        ib.id_allowin     = a;
        flush             = f;
        @(negedge clk);
        if (f) begin
            sb.delete();
        end else if (v && ib.ib_allowin) begin
            sb.push_back(bundle(pc));
        end
        @(posedge clk);
        #1;
        ib.if_to_ib_valid = 1'b0;
        flush             = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 16 && !ib_empty; i++) begin
            cycle(1'b0, 64'h0, 1'b1, 1'b0);
        end
        chk("drain_empty", {95'b0, ib_empty}, 96'd1);
        chk("drain_sb_empty", 96'(sb.size()), 96'd0);
    endtask

    // Monitor: every bundle ID takes must be the oldest expected one.
    always begin
        @(negedge clk);
        #1;
        if (!rst && !flush && ib.ib_to_id_valid && ib.id_allowin) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL head_order: got %h expected no output", ib.ib_to_id_bus);
            end else begin
                logic [DATA_W-1:0] e;
                e = sb.pop_front();
                if (ib.ib_to_id_bus !== e) begin
                    errors++;
                    $display("FAIL head_order: got %h expected %h", ib.ib_to_id_bus, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  a_pat;
        int          sent;
        logic [63:0] pc;

        rst               = 1'b1;
        flush             = 1'b0;
        ib.if_to_ib_valid = 1'b0;
        ib.if_to_ib_bus   = '0;
        ib.id_allowin     = 1'b0;
        #12;
        chk("rst_count", 96'(ib_count), 96'd0);
        chk("rst_empty", {95'b0, ib_empty}, 96'd1);
        chk("rst_full", {95'b0, ib_full}, 96'd0);
        chk("rst_valid", {95'b0, ib.ib_to_id_valid}, 96'd0);
        chk("rst_bus", ib.ib_to_id_bus, 96'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_allowin", {95'b0, ib.ib_allowin}, 96'd1);

        // Fill to DEPTH with ID stalled.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 64'h8000_0000 + 64'(4 * i), 1'b0, 1'b0);
        end
        chk("fill_full", {95'b0, ib_full}, 96'd1);
        chk("fill_allowin", {95'b0, ib.ib_allowin}, 96'd0);
        chk("fill_count", 96'(ib_count), 96'd4);
        cycle(1'b1, 64'h8000_0099, 1'b0, 1'b0);
        chk("fill_5th_count", 96'(ib_count), 96'd4);
        chk("fill_head", 96'(ib.ib_to_id_bus[95:32]), 96'h8000_0000);

        // Push and pop while full.
        cycle(1'b1, 64'h8000_0010, 1'b1, 1'b0);
        chk("fullpp_count", 96'(ib_count), 96'd4);
        chk("fullpp_head", 96'(ib.ib_to_id_bus[95:32]), 96'h8000_0004);
        drain();

        // Wrap-around stream with ID stalling in a 1,0,1,1,0 pattern.
        a_pat = 5'b01101;
        sent  = 0;
        for (int c = 0; c < 200 && sent < 20; c++) begin
            pc = 64'h8000_1000 + 64'(4 * sent);
            ib.if_to_ib_valid = 1'b1;
            ib.id_allowin     = a_pat[c % 5];
            #1;
            if (ib.ib_allowin) sent++;
            cycle(1'b1, pc, a_pat[c % 5], 1'b0);
        end
        chk("wrap_sent", 96'(sent), 96'd20);
        drain();

        // Flush with three entries held and a simultaneous push.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 64'h8000_0080 + 64'(4 * i), 1'b0, 1'b0);
        end
        chk("pre_flush_count", 96'(ib_count), 96'd3);
        cycle(1'b1, 64'h8000_0100, 1'b0, 1'b1);
        chk("flush_count", 96'(ib_count), 96'd0);
        chk("flush_valid", {95'b0, ib.ib_to_id_valid}, 96'd0);
        cycle(1'b1, 64'h8000_0200, 1'b0, 1'b0);
        chk("post_flush_head", 96'(ib.ib_to_id_bus[95:32]), 96'h8000_0200);
        drain();

        // Empty buffer, producer and consumer both ready.
        ib.if_to_ib_valid = 1'b1;
        ib.if_to_ib_bus   = bundle(64'h8000_0040);
        ib.id_allowin     = 1'b1;
        #1;
`ifdef YSYX_22051086_IBUF_BYPASS_EN
        chk("byp_valid", {95'b0, ib.ib_to_id_valid}, 96'd1);
        chk("byp_bus", ib.ib_to_id_bus, bundle(64'h8000_0040));
        cycle(1'b1, 64'h8000_0040, 1'b1, 1'b0);
        chk("byp_count", 96'(ib_count), 96'd0);
`else
        chk("nobyp_valid", {95'b0, ib.ib_to_id_valid}, 96'd0);
        cycle(1'b1, 64'h8000_0040, 1'b1, 1'b0);
        chk("nobyp_count", 96'(ib_count), 96'd1);
        chk("nobyp_bus", ib.ib_to_id_bus, bundle(64'h8000_0040));
`endif
        drain();

        // Asynchronous reset with three entries held.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 64'h8000_0300 + 64'(4 * i), 1'b0, 1'b0);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", 96'(ib_count), 96'd0);
        chk("arst_empty", {95'b0, ib_empty}, 96'd1);
        chk("arst_valid", {95'b0, ib.ib_to_id_valid}, 96'd0);
        chk("arst_bus", ib.ib_to_id_bus, 96'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_allowin", {95'b0, ib.ib_allowin}, 96'd1);
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ysyx_22051086_id_ibuf.md
Name: ysyx_22051086_id_ibuf

Overview:
- Parametrised instruction buffer between IFU and IDU. It replaces the single-entry if_to_id register with a DEPTH-entry circular FIFO of {pc, inst} bundles.
- Uses the pipeline valid/allowin handshake on both sides. Supports a one-cycle flush on redirect (branch taken, ecall, mret).
- Lets IF keep fetching while ID is stalled by load-use hazards.

Parameters:
- DATA_W, 96: bundle width; {pc[63:0], inst[31:0]} by default.
- DEPTH, 4: number of entries. Power of two, DEPTH >= 2.
- CNT_W, $clog2(DEPTH)+1: width of the occupancy counter and of the pointers (pointers include a wrap bit).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_to_ib_valid  in  1  IF offers a bundle.
- ib_allowin  out  1  buffer accepts a bundle this cycle.
- if_to_ib_bus  in  DATA_W  bundle from IF.
- ib_to_id_valid  out  1  head entry is valid.
- id_allowin  in  1  ID consumes the head this cycle.
- ib_to_id_bus  out  DATA_W  head bundle.
- flush  in  1  discard all contents (redirect).
- ib_count  out  CNT_W  current occupancy, 0..DEPTH.
- ib_full  out  1  ib_count == DEPTH.
- ib_empty  out  1  ib_count == 0.

Behaviour:
- Reset (async, rst=1):
  - rptr = wptr = 0, ib_count = 0.
  - ib_to_id_valid = 0, ib_empty = 1, ib_full = 0, ib_to_id_bus = 0.
  - ib_allowin = 1 once rst deasserts.
  - Storage array is not reset.
- Handshake events:
  - push = if_to_ib_valid && ib_allowin.
  - pop = ib_to_id_valid && id_allowin.
- ib_allowin = !ib_full || pop. A push while full is legal only when there is a same-cycle pop; ib_allowin is combinational on id_allowin.
- ib_to_id_valid = !ib_empty.
- ib_to_id_bus = mem[rptr] when not empty, else 0. Combinational read of the registered array; no added latency.
- Latency: a bundle pushed in cycle N is visible at ib_to_id_bus in cycle N+1 at the earliest.
- Ordering is strict FIFO; no reordering and no duplication.
- Pointer update:
  - wptr advances on push, rptr advances on pop, both modulo 2*DEPTH.
  - The index is the low $clog2(DEPTH) bits.
  - full = (index equal and wrap bit differs); empty = (pointers equal).
- Counter update: ib_count += push - pop. A simultaneous push and pop leaves it unchanged (allowed at empty+push? see below).
- Empty boundary: pop is impossible when empty. A push to an empty buffer gives count 1 next cycle.
- Full boundary: push && pop while full keeps count = DEPTH. The new entry is written at the slot just freed, and rptr/wptr both advance.
- Flush has priority over push and pop in the same cycle:
  - Next cycle: rptr = wptr, ib_count = 0, ib_to_id_valid = 0.
  - A bundle pushed in the flush cycle is dropped.
  - ib_allowin stays asserted during flush (the producer sees acceptance). IF is responsible for squashing its redirect-cycle fetch.
- Reset mid-operation: all contents are lost immediately. Outputs take their reset values asynchronously.
- No state machine beyond the pointers and the counter. The block is a pure buffer and does not decode.

Optional Feature:
- Macro: YSYX_22051086_IBUF_BYPASS_EN.
- Defined:
  - When ib_empty && if_to_ib_valid && !flush, ib_to_id_valid = 1 and ib_to_id_bus = if_to_ib_bus in the same cycle (zero latency).
  - If id_allowin is also 1, the bundle is consumed and is not written; pointers and count are unchanged.
  - If id_allowin = 0, the bundle is written normally; count becomes 1 next cycle.
- Undefined: minimum latency is 1 cycle as specified above. ib_to_id_valid depends only on state.

Test Plan:
- Reset: rst pulse mid-cycle with 3 entries held → same cycle ib_count=0, ib_empty=1, ib_to_id_valid=0, ib_to_id_bus=0.
- Fill: id_allowin=0, push pc=0x80000000, +4, +8, +0xC (DEPTH=4) → ib_full=1 and ib_allowin=0 after the 4th push. A 5th offer is not accepted; the head stays pc 0x80000000.
- Full push+pop: at full, id_allowin=1 and push pc 0x80000010 → ib_count stays 4. The head becomes 0x80000004, and 0x80000010 drains last.
- Wrap-around: stream 20 bundles with id_allowin toggling 1,0,1,1,0 → the output sequence equals the input sequence exactly, with no loss after pointer wrap.
- Flush: with 3 entries and a simultaneous push of pc 0x80000100, assert flush → next cycle ib_count=0, ib_to_id_valid=0. The next pushed pc 0x80000200 is the first output.
- Bypass (macro defined): empty buffer, if_to_ib_valid=1, id_allowin=1, pc 0x80000040 → ib_to_id_valid=1 and bus=pc 0x80000040 in the same cycle, ib_count stays 0. With the macro undefined, it appears one cycle later with ib_count briefly 1.
